// File: rtl/joy2quad_multi.sv
// Multi-channel joystick-to-quadrature steering emulator with a per-channel acceleration ramp.
// Define JOY2QUAD_POS_EN to add the per-channel signed net step counter output 'pos'.

module joy2quad_chan #(
    parameter int DIV_W      = 16,
    parameter int RAMP_STEPS = 3,
    parameter int RAMP_HOLD  = 4
) (
    input  logic             CLK,
    input  logic             Reset_n,
    input  logic [DIV_W-1:0] clkdiv,
    input  logic             right,
    input  logic             left,
    output logic [1:0]       steer,
    output logic             step_stb,
`ifdef JOY2QUAD_POS_EN
    output logic [7:0]       pos,
`endif
    output logic [2:0]       level
);
    localparam int HW = (RAMP_HOLD > 1) ? $clog2(RAMP_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_MAX = HW'(RAMP_HOLD - 1);
    localparam logic [2:0]    LVL_MAX  = 3'(RAMP_STEPS - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q;
    logic             neg_q;
    logic [DIV_W-1:0] div_q;
    logic [HW-1:0]    hold_q;
    logic [2:0]       level_q;
    logic [1:0]       steer_q;
    logic             stb_q;
`ifdef JOY2QUAD_POS_EN
    logic [7:0]       pos_q;
`endif

    logic             req, req_neg, div_hit;
    logic [DIV_W-1:0] base, shifted, iv;
    logic [1:0]       idx, idx_d, steer_d;

    assign req     = right ^ left;
    assign req_neg = left;
    assign base    = (clkdiv == '0) ? DIV_W'(1) : clkdiv;
    assign shifted = base >> level_q;
    assign iv      = (shifted == '0) ? DIV_W'(1) : shifted;
    // >= so a shrinking clkdiv mid-count fires the step at once instead of wrapping
    assign div_hit = (div_q >= iv - DIV_W'(1));

    // Gray <-> binary so the phase can be stepped as a plain 2-bit counter
    assign idx     = {steer_q[1], steer_q[1] ^ steer_q[0]};
    assign idx_d   = neg_q ? idx - 2'd1 : idx + 2'd1;
    assign steer_d = {idx_d[1], idx_d[1] ^ idx_d[0]};

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            neg_q   <= 1'b0;
            div_q   <= '0;
            hold_q  <= '0;
            level_q <= '0;
            steer_q <= '0;
            stb_q   <= 1'b0;
`ifdef JOY2QUAD_POS_EN
            pos_q   <= '0;
`endif
        end else begin
            stb_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    div_q   <= '0;
                    hold_q  <= '0;
                    level_q <= '0;
                    if (req) begin
                        state_q <= RUN;
                        neg_q   <= req_neg;
                    end
                end
                RUN: begin
                    if (!req) begin
                        state_q <= IDLE;
                        div_q   <= '0;
                        hold_q  <= '0;
                        level_q <= '0;
                    end else if (req_neg != neg_q) begin
                        neg_q   <= req_neg;
                        div_q   <= '0;
                        hold_q  <= '0;
                        level_q <= '0;
                    end else if (div_hit) begin
                        steer_q <= steer_d;
                        stb_q   <= 1'b1;
                        div_q   <= '0;
`ifdef JOY2QUAD_POS_EN
                        pos_q   <= neg_q ? pos_q - 8'd1 : pos_q + 8'd1;
`endif
                        if (hold_q == HOLD_MAX && level_q < LVL_MAX) begin
                            level_q <= level_q + 3'd1;
                            hold_q  <= '0;
                        end else if (hold_q != HOLD_MAX) begin
                            hold_q  <= hold_q + HW'(1);
                        end
                    end else begin
                        div_q <= div_q + DIV_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign steer    = steer_q;
    assign step_stb = stb_q;
    assign level    = level_q;
`ifdef JOY2QUAD_POS_EN
    assign pos      = pos_q;
`endif
endmodule

module joy2quad_multi #(
    parameter int CHANNELS   = 2,
    parameter int DIV_W      = 16,
    parameter int RAMP_STEPS = 3,
    parameter int RAMP_HOLD  = 4
) (
    input  logic                  CLK,
    input  logic                  Reset_n,
    input  logic [DIV_W-1:0]      clkdiv,
    input  logic [CHANNELS-1:0]   right,
    input  logic [CHANNELS-1:0]   left,
    output logic [2*CHANNELS-1:0] steer,
    output logic [CHANNELS-1:0]   step_stb,
`ifdef JOY2QUAD_POS_EN
    output logic [8*CHANNELS-1:0] pos,
`endif
    output logic [3*CHANNELS-1:0] level
);
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        joy2quad_chan #(
            .DIV_W     (DIV_W),
            .RAMP_STEPS(RAMP_STEPS),
            .RAMP_HOLD (RAMP_HOLD)
        ) u_ch (
            .CLK     (CLK),
            .Reset_n (Reset_n),
            .clkdiv  (clkdiv),
            .right   (right[c]),
            .left    (left[c]),
            .steer   (steer[2*c+1:2*c]),
            .step_stb(step_stb[c]),
`ifdef JOY2QUAD_POS_EN
            .pos     (pos[8*c+7:8*c]),
`else
`endif
            .level   (level[3*c+2:3*c])
        );
    end
endmodule

// File: tb/tb_joy2quad_multi.sv
// Table-driven and scoreboard bench for joy2quad_multi (2 channels, RAMP_STEPS=3, RAMP_HOLD=2).
module tb_joy2quad_multi;
    localparam int CH = 2;

    logic          CLK = 1'b0;
    logic          Reset_n;
    logic [15:0]   clkdiv;
    logic [CH-1:0] right, left;
    logic [2*CH-1:0] steer;
    logic [CH-1:0] step_stb;
    logic [3*CH-1:0] level;
`ifdef JOY2QUAD_POS_EN
    logic [8*CH-1:0] pos;
`endif

    joy2quad_multi #(.CHANNELS(CH), .DIV_W(16), .RAMP_STEPS(3), .RAMP_HOLD(2)) dut (
        .CLK(CLK), .Reset_n(Reset_n), .clkdiv(clkdiv), .right(right), .left(left),
        .steer(steer), .step_stb(step_stb),
`ifdef JOY2QUAD_POS_EN
        .pos(pos),
`endif
        .level(level)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [2*CH-1:0] steer;
        logic [CH-1:0]   stb;
        logic [3*CH-1:0] level;
        logic [8*CH-1:0] pos;
    } exp_t;

    typedef struct {
        logic [1:0] r, l;
        logic [15:0] cd;
        int n;
        logic [1:0] st0;
        logic [2:0] lv0;
        int s0, s1;
    } seg_t;

    exp_t sb_q[$];
    int n_cmp = 0, n_bad = 0;
    int steps0, steps1;

    // reference model state
    int m_run[CH], m_dir[CH], m_div[CH], m_hold[CH], m_lvl[CH], m_idx[CH], m_pos[CH];
    logic [CH-1:0] m_stb;

    function automatic logic [1:0] gray(input int i);
        case (i & 3)
            0: return 2'b00;
            1: return 2'b01;
            2: return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_run[c] = 0; m_dir[c] = 0; m_div[c] = 0; m_hold[c] = 0;
            m_lvl[c] = 0; m_idx[c] = 0; m_pos[c] = 0;
        end
        m_stb = '0;
    endtask

    task automatic model_step(input logic [1:0] r, input logic [1:0] l, input logic [15:0] cd);
        for (int c = 0; c < CH; c++) begin
            int d, iv;
            d = (r[c] && !l[c]) ? 1 : (l[c] && !r[c]) ? -1 : 0;
            m_stb[c] = 1'b0;
            if (m_run[c] == 0) begin
                m_div[c] = 0; m_hold[c] = 0; m_lvl[c] = 0;
                if (d != 0) begin m_run[c] = 1; m_dir[c] = d; end
            end else if (d == 0) begin
                m_run[c] = 0; m_div[c] = 0; m_hold[c] = 0; m_lvl[c] = 0;
            end else if (d != m_dir[c]) begin
                m_dir[c] = d; m_div[c] = 0; m_hold[c] = 0; m_lvl[c] = 0;
            end else begin
                iv = ((cd == 0) ? 1 : int'(cd)) >> m_lvl[c];
                if (iv == 0) iv = 1;
                if (m_div[c] + 1 >= iv) begin
                    m_stb[c] = 1'b1;
                    m_div[c] = 0;
                    m_idx[c] = (m_idx[c] + d) & 3;
                    m_pos[c] = (m_pos[c] + d) & 255;
                    if (m_hold[c] == 1 && m_lvl[c] < 2) begin
                        m_lvl[c]++; m_hold[c] = 0;
                    end else if (m_hold[c] < 1) m_hold[c]++;
                end else m_div[c]++;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // drive one cycle at negedge, push expectation, sample at the next negedge
    task automatic tick(input logic [1:0] r, input logic [1:0] l, input logic [15:0] cd);
        exp_t e;
        right = r; left = l; clkdiv = cd;
        model_step(r, l, cd);
        e.stb = m_stb;
        e.pos = '0;
        for (int c = 0; c < CH; c++) begin
            e.steer[2*c +: 2] = gray(m_idx[c]);
            e.level[3*c +: 3] = 3'(m_lvl[c]);
            e.pos[8*c +: 8]   = 8'(m_pos[c]);
        end
        sb_q.push_back(e);
        @(posedge CLK);
        @(negedge CLK);
        e = sb_q.pop_front();
        chk("steer", 32'(steer), 32'(e.steer));
        chk("step_stb", 32'(step_stb), 32'(e.stb));
        chk("level", 32'(level), 32'(e.level));
`ifdef JOY2QUAD_POS_EN
        chk("pos", 32'(pos), 32'(e.pos));
`endif
        if (step_stb[0]) steps0++;
        if (step_stb[1]) steps1++;
    endtask

    seg_t segs[12];

    initial begin
        // r, l, clkdiv, cycles, ch0 steer, ch0 level, ch0 steps, ch1 steps
        segs[0]  = '{2'b01, 2'b00, 16'd4,     5,  2'b01, 3'd0, 1, 0}; // first step on 4th RUN cycle
        segs[1]  = '{2'b01, 2'b00, 16'd4,     4,  2'b11, 3'd1, 1, 0}; // second step promotes
        segs[2]  = '{2'b00, 2'b00, 16'd4,     1,  2'b11, 3'd0, 0, 0}; // release -> idle
        segs[3]  = '{2'b01, 2'b00, 16'd8,     29, 2'b00, 3'd2, 6, 0}; // gaps 8,8,4,4,2,2
        segs[4]  = '{2'b00, 2'b01, 16'd8,     1,  2'b00, 3'd0, 0, 0}; // reversal, no step
        segs[5]  = '{2'b00, 2'b01, 16'd8,     8,  2'b10, 3'd0, 1, 0}; // full interval then reverse step
        segs[6]  = '{2'b10, 2'b11, 16'd8,     8,  2'b11, 3'd1, 1, 0}; // ch1 both pressed frozen
        segs[7]  = '{2'b01, 2'b00, 16'd0,     1,  2'b11, 3'd0, 0, 0}; // reversal back to right
        segs[8]  = '{2'b01, 2'b00, 16'd0,     4,  2'b11, 3'd2, 4, 0}; // clkdiv 0 -> every cycle
        segs[9]  = '{2'b01, 2'b00, 16'h0100,  10, 2'b11, 3'd2, 0, 0}; // long interval, counting
        segs[10] = '{2'b01, 2'b00, 16'd8,     1,  2'b10, 3'd2, 1, 0}; // shrink: immediate step
        segs[11] = '{2'b10, 2'b00, 16'd2,     3,  2'b10, 3'd0, 0, 1}; // ch1 alone steps

        Reset_n = 1'b0; right = 2'b01; left = 2'b00; clkdiv = 16'd4;
        model_reset();
        repeat (3) @(negedge CLK);
        chk("reset_steer", 32'(steer), 32'd0);
        chk("reset_stb", 32'(step_stb), 32'd0);
        chk("reset_level", 32'(level), 32'd0);
        Reset_n = 1'b1;

        foreach (segs[i]) begin
            steps0 = 0; steps1 = 0;
            repeat (segs[i].n) tick(segs[i].r, segs[i].l, segs[i].cd);
            chk($sformatf("seg%0d_steer0", i), 32'(steer[1:0]), 32'(segs[i].st0));
            chk($sformatf("seg%0d_level0", i), 32'(level[2:0]), 32'(segs[i].lv0));
            chk($sformatf("seg%0d_steps0", i), 32'(steps0), 32'(segs[i].s0));
            chk($sformatf("seg%0d_steps1", i), 32'(steps1), 32'(segs[i].s1));
        end

        // asynchronous reset mid-run
        repeat (3) tick(2'b11, 2'b00, 16'd1);
        #2 Reset_n = 1'b0;
        #1;
        chk("async_rst_steer", 32'(steer), 32'd0);
        chk("async_rst_level", 32'(level), 32'd0);
        chk("async_rst_stb", 32'(step_stb), 32'd0);
        model_reset();
        @(negedge CLK);
        Reset_n = 1'b1;

        // 130 steps at clkdiv=1: net count wraps 127 -> -128
        steps0 = 0;
        repeat (128) tick(2'b01, 2'b00, 16'd1);
`ifdef JOY2QUAD_POS_EN
        chk("pos_127", 32'(pos[7:0]), 32'h7f);
`endif
        tick(2'b01, 2'b00, 16'd1);
`ifdef JOY2QUAD_POS_EN
        chk("pos_wrap", 32'(pos[7:0]), 32'h80);
`endif
        repeat (2) tick(2'b01, 2'b00, 16'd1);
`ifdef JOY2QUAD_POS_EN
        chk("pos_m126", 32'(pos[7:0]), 32'h82);
`endif
        chk("long_steps", 32'(steps0), 32'd130);
        chk("long_steer", 32'(steer[1:0]), 32'b11);
        chk("long_level", 32'(level[2:0]), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
